// File: rtl/conv_stream_tx_if.sv
// Word-write port, run control and kernel/pixel stream outputs of conv_stream_tx.
// The master side drives the buffers and control; the slave side is the transmitter.
interface conv_stream_tx_if #(
    parameter int unsigned BITS   = 9,
    parameter int unsigned ADDR_W = 6
);
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [BITS-1:0]   wr_data;
    logic              start;
    logic              skip_kernel;
    logic [ADDR_W:0]   img_len;
    logic              hold;
    logic              kernel_write_en;
    logic [BITS-1:0]   kernel_out;
    logic              img_write_en;
    logic [BITS-1:0]   img_out;
    logic              busy;
    logic              done;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, skip_kernel, img_len, hold,
        input  kernel_write_en, kernel_out, img_write_en, img_out, busy, done
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, skip_kernel, img_len, hold,
        output kernel_write_en, kernel_out, img_write_en, img_out, busy, done
    );
endinterface

// File: rtl/conv_stream_tx.sv
// Buffers one kernel and one image run, then replays them (kernel first, then pixels)
// onto the convolver's write lines with stall, kernel-skip and a done pulse.
module conv_stream_tx #(
    parameter int unsigned BITS        = 9,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned ADDR_W      = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    conv_stream_tx_if.slave bus
);
    localparam int unsigned KSQ       = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned IMG_DEPTH = 1 << ADDR_W;
    localparam int unsigned KIDX_W    = (KSQ > 1) ? $clog2(KSQ) : 1;
    localparam int unsigned LEN_W     = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_KERNEL = 2'd1,
        S_IMAGE  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [KIDX_W-1:0] kidx_q, kidx_d;
    logic [ADDR_W-1:0] iidx_q, iidx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              kernel_write_en_q, kernel_write_en_d;
    logic [BITS-1:0]   kernel_out_q, kernel_out_d;
    logic              img_write_en_q, img_write_en_d;
    logic [BITS-1:0]   img_out_q, img_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [BITS-1:0]   kbuf_q [KSQ];
    logic [BITS-1:0]   ibuf_q [IMG_DEPTH];

    logic              idle_vis;
    logic              launch;
    logic              wr_k_ok;
    logic              wr_i_ok;
    logic              step;
    logic              k_last;
    logic              i_last;
    logic [LEN_W-1:0]  len_start;
    logic [BITS-1:0]   k_word0;
    logic [BITS-1:0]   i_word0;

    // Registered outputs lag the state by one cycle, so the visible done cycle is
    // already back in S_IDLE and must still block writes and start.
    assign idle_vis  = (state_q == S_IDLE) && !done_q;
    assign launch    = idle_vis && bus.start;
    assign wr_k_ok   = idle_vis && bus.wr_en && bus.wr_sel && (32'(bus.wr_addr) < KSQ);
    assign wr_i_ok   = idle_vis && bus.wr_en && !bus.wr_sel;
    assign step      = !bus.hold;
    assign k_last    = (kidx_q == KIDX_W'(KSQ - 1));
    assign i_last    = ({1'b0, iidx_q} == (len_q - LEN_W'(1)));
    assign len_start = (bus.img_len > LEN_W'(IMG_DEPTH)) ? LEN_W'(IMG_DEPTH) : bus.img_len;

    // The first word leaves on the start edge, so a same-cycle write to word 0 is forwarded.
    assign k_word0 = (wr_k_ok && (bus.wr_addr == '0)) ? bus.wr_data : kbuf_q[0];
    assign i_word0 = (wr_i_ok && (bus.wr_addr == '0)) ? bus.wr_data : ibuf_q[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kidx_q            <= '0;
            iidx_q            <= '0;
            len_q             <= '0;
            kernel_write_en_q <= 1'b0;
            kernel_out_q      <= '0;
            img_write_en_q    <= 1'b0;
            img_out_q         <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            kidx_q            <= kidx_d;
            iidx_q            <= iidx_d;
            len_q             <= len_d;
            kernel_write_en_q <= kernel_write_en_d;
            kernel_out_q      <= kernel_out_d;
            img_write_en_q    <= img_write_en_d;
            img_out_q         <= img_out_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
        end
    end

    // Buffer storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_k_ok) begin
            kbuf_q[KIDX_W'(bus.wr_addr)] <= bus.wr_data;
        end
        if (wr_i_ok) begin
            ibuf_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (launch) begin
                    if (!bus.skip_kernel) begin
                        if (KSQ == 1) begin
                            state_d = (len_start != '0) ? S_IMAGE : S_DONE;
                        end else begin
                            state_d = S_KERNEL;
                        end
                    end else if (len_start == '0) begin
                        state_d = S_IDLE;
                    end else if (len_start == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IMAGE;
                    end
                end
            end
            S_KERNEL: begin
                if (step && k_last) begin
                    state_d = (len_q != '0) ? S_IMAGE : S_DONE;
                end
            end
            S_IMAGE: begin
                if (step && i_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        kidx_d            = kidx_q;
        iidx_d            = iidx_q;
        len_d             = len_q;
        kernel_write_en_d = 1'b0;
        kernel_out_d      = kernel_out_q;
        img_write_en_d    = 1'b0;
        img_out_d         = img_out_q;
        busy_d            = 1'b0;
        done_d            = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (launch) begin
                    len_d  = len_start;
                    kidx_d = '0;
                    iidx_d = '0;
                    if (!bus.skip_kernel) begin
                        kernel_write_en_d = 1'b1;
                        kernel_out_d      = k_word0;
                        kidx_d            = KIDX_W'(1);
                        busy_d            = 1'b1;
                    end else if (len_start != '0) begin
                        img_write_en_d = 1'b1;
                        img_out_d      = i_word0;
                        iidx_d         = ADDR_W'(1);
                        busy_d         = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_KERNEL: begin
                busy_d = 1'b1;
                if (step) begin
                    kernel_write_en_d = 1'b1;
                    kernel_out_d      = kbuf_q[kidx_q];
                    kidx_d            = kidx_q + KIDX_W'(1);
                end
            end
            S_IMAGE: begin
                busy_d = 1'b1;
                if (step) begin
                    img_write_en_d = 1'b1;
                    img_out_d      = ibuf_q[iidx_q];
                    iidx_d         = iidx_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    assign bus.kernel_write_en = kernel_write_en_q;
    assign bus.kernel_out      = kernel_out_q;
    assign bus.img_write_en    = img_write_en_q;
    assign bus.img_out         = img_out_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;

endmodule

// File: tb/tb_conv_stream_tx.sv
// Scoreboard bench for conv_stream_tx: a word-list/timing model predicts every emitted
// word, pixel and done pulse; an independent monitor pops and compares on each output.
module tb_conv_stream_tx;
    localparam int unsigned BITS   = 9;
    localparam int unsigned KS     = 3;
    localparam int unsigned ADDR_W = 6;
    localparam int          KSQ    = 9;
    localparam int          DEPTH  = 64;
    localparam int          HMAX   = 1024;

    typedef struct {
        int kind;   // 0 kernel word, 1 pixel, 2 done
        int data;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    conv_stream_tx_if #(.BITS(BITS), .ADDR_W(ADDR_W)) bus ();

    conv_stream_tx #(.BITS(BITS), .KERNEL_SIZE(KS), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    int   kb[KSQ];
    int   ib[DEPTH];
    bit   hold_pat[HMAX];
    int   b_from = 1;
    int   b_to = 0;
    int   last_k = 0;
    int   last_i = 0;
    int   done_cyc = -1;
    int   n_pix = 0;
    int   n_ker = 0;
    int   last_pix = -1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_evt(input int kind, input int data);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %0d at cycle %0d, expected nothing",
                     kind, data, cyc);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.data != data || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got kind %0d data %0d cycle %0d expected kind %0d data %0d cycle %0d",
                         kind, data, cyc, e.kind, e.data, e.cyc);
            end
            if (e.kind == 0) last_k = e.data;
            if (e.kind == 1) last_i = e.data;
        end
    endfunction

    // Monitor: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("busy", int'(bus.busy), (cyc >= b_from && cyc <= b_to) ? 1 : 0);
        if (bus.kernel_write_en) begin
            n_ker++;
            expect_evt(0, int'(bus.kernel_out));
        end else begin
            chk("kernel_out_hold", int'(bus.kernel_out), last_k);
        end
        if (bus.img_write_en) begin
            n_pix++;
            last_pix = int'(bus.img_out);
            expect_evt(1, int'(bus.img_out));
        end else begin
            chk("img_out_hold", int'(bus.img_out), last_i);
        end
        if (bus.done) begin
            done_cyc = cyc;
            expect_evt(2, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.wr_en = 1'b0;
            bus.start = 1'b0;
            bus.hold  = 1'b0;
        end
    endtask

    function automatic void model_write(input int sel, input int addr, input int data);
        if (sel != 0 && addr < KSQ) kb[addr] = data;
        if (sel == 0) ib[addr] = data;
    endfunction

    task automatic write_word(input int sel, input int addr, input int data);
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.hold    = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'(sel);
        bus.wr_addr = 6'(addr);
        bus.wr_data = 9'(data);
        model_write(sel, addr, data);
    endtask

    function automatic void clear_hold();
        for (int i = 0; i < HMAX; i++) hold_pat[i] = 1'b0;
    endfunction

    // One run: start in cycle t, model the emitted sequence, drive until after done.
    task automatic run_txn(input bit skip, input int len, input int junk, input bit fwd,
                           input int abort_at, output int t_o);
        exp_t words[$];
        exp_t e;
        int   t, eff, v, ev, dc, sel, addr, data;
        @(posedge clk); #1;
        t = cyc;
        t_o = t;
        done_cyc = -1;
        n_pix = 0;
        n_ker = 0;
        bus.start       = 1'b1;
        bus.skip_kernel = skip;
        bus.img_len     = 7'(len);
        bus.hold        = hold_pat[0];
        bus.wr_en       = 1'b0;
        if (fwd) begin
            sel  = int'($urandom_range(0, 1));
            addr = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, sel != 0 ? 11 : 63));
            data = int'($urandom_range(0, 511));
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 1'(sel);
            bus.wr_addr = 6'(addr);
            bus.wr_data = 9'(data);
            model_write(sel, addr, data);
        end
        if (!skip) begin
            for (int i = 0; i < KSQ; i++) begin
                e.kind = 0; e.data = kb[i]; e.cyc = 0;
                words.push_back(e);
            end
        end
        eff = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < eff; i++) begin
            e.kind = 1; e.data = ib[i]; e.cyc = 0;
            words.push_back(e);
        end
        v = t;
        for (int i = 0; i < words.size(); i++) begin
            if (i == 0) begin
                v = t + 1;
            end else begin
                ev = v;
                while ((ev - t) < HMAX && hold_pat[ev - t]) ev++;
                v = ev + 1;
            end
            words[i].cyc = v;
            sbq.push_back(words[i]);
        end
        dc = (words.size() == 0) ? t + 1 : v + 1;
        e.kind = 2; e.data = 0; e.cyc = dc;
        sbq.push_back(e);
        b_from = t + 1;
        b_to   = (words.size() == 0) ? t : v;

        for (int k = 1; k < 4000; k++) begin
            @(posedge clk); #1;
            if (abort_at != 0 && k == abort_at) begin
                #2;
                reset_n = 1'b0;
                #1;
                chk("rst_enables_busy_done",
                    int'({bus.kernel_write_en, bus.img_write_en, bus.busy, bus.done}), 0);
                chk("rst_kernel_out", int'(bus.kernel_out), 0);
                chk("rst_img_out", int'(bus.img_out), 0);
                sbq.delete();
                b_from = 1; b_to = 0;
                last_k = 0; last_i = 0;
                bus.start = 1'b0; bus.wr_en = 1'b0; bus.hold = 1'b0;
                @(posedge clk); @(posedge clk); #1;
                reset_n = 1'b1;
                break;
            end
            if (cyc > dc) begin
                bus.start = 1'b0;
                bus.wr_en = 1'b0;
                bus.hold  = 1'b0;
                break;
            end
            bus.hold = (k < HMAX) ? hold_pat[k] : 1'b0;
            if (junk == 1) begin
                bus.start       = ($urandom_range(0, 3) == 0);
                bus.skip_kernel = 1'($urandom_range(0, 1));
                bus.img_len     = 7'($urandom_range(0, 127));
                bus.wr_en       = 1'($urandom_range(0, 1));
                bus.wr_sel      = 1'($urandom_range(0, 1));
                bus.wr_addr     = 6'($urandom);
                bus.wr_data     = 9'($urandom);
            end else if (junk == 2) begin
                bus.start   = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'b0;
                bus.wr_addr = 6'd0;
                bus.wr_data = 9'h1FF;
            end else begin
                bus.start = 1'b0;
                bus.wr_en = 1'b0;
            end
        end
    endtask

    initial begin
        int t;
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.skip_kernel = 1'b0; bus.img_len = '0; bus.hold = 1'b0;
        clear_hold();

        #2 reset_n = 1'b0;
        #1;
        chk("reset_enables_busy_done",
            int'({bus.kernel_write_en, bus.img_write_en, bus.busy, bus.done}), 0);
        chk("reset_data", int'({bus.kernel_out, bus.img_out}), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < KSQ; i++) write_word(1, i, i + 1);
        for (int i = 0; i < DEPTH; i++) write_word(0, i, (i < 4) ? 10 + i : (i * 7 + 3) % 512);
        idle_cycles(2);

        // Full run: kernel 1..9 then pixels 10..13.
        run_txn(1'b0, 4, 0, 1'b0, 0, t);
        chk("full_done_latency", done_cyc - t, 14);
        chk("full_kernel_count", n_ker, 9);
        chk("full_pixel_count", n_pix, 4);
        idle_cycles(2);

        // Kernel skipped.
        run_txn(1'b1, 2, 0, 1'b0, 0, t);
        chk("skip_done_latency", done_cyc - t, 3);
        chk("skip_kernel_count", n_ker, 0);
        idle_cycles(1);

        // Two-cycle stall after the third kernel word.
        hold_pat[3] = 1'b1;
        hold_pat[4] = 1'b1;
        run_txn(1'b0, 4, 0, 1'b0, 0, t);
        chk("hold_done_latency", done_cyc - t, 16);
        clear_hold();
        idle_cycles(1);

        // Empty run and clamped run.
        run_txn(1'b1, 0, 0, 1'b0, 0, t);
        chk("empty_done_latency", done_cyc - t, 1);
        chk("empty_pixel_count", n_pix, 0);
        run_txn(1'b0, 100, 0, 1'b0, 0, t);
        chk("clamp_pixel_count", n_pix, 64);
        chk("clamp_done_latency", done_cyc - t, 74);
        idle_cycles(1);

        // Writes and start while busy are ignored.
        run_txn(1'b0, 4, 2, 1'b0, 0, t);
        run_txn(1'b1, 1, 0, 1'b0, 0, t);
        chk("busy_write_ignored", last_pix, 10);
        idle_cycles(1);

        // Reset during the image phase, then a fresh run from index 0.
        run_txn(1'b0, 20, 0, 1'b0, 12, t);
        idle_cycles(4);
        run_txn(1'b1, 3, 0, 1'b0, 0, t);
        chk("post_reset_first_pixels", n_pix, 3);
        chk("post_reset_last_pixel", last_pix, 12);
        idle_cycles(1);

        // Randomized runs with reloads, stalls, forwarding and ignored traffic.
        for (int it = 0; it < 30; it++) begin
            int nw;
            nw = int'($urandom_range(0, 12));
            for (int w = 0; w < nw; w++) begin
                int s;
                s = int'($urandom_range(0, 1));
                write_word(s, int'($urandom_range(0, s != 0 ? 15 : 63)), int'($urandom_range(0, 511)));
            end
            for (int i = 0; i < HMAX; i++) hold_pat[i] = ($urandom_range(0, 3) == 0);
            run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 80)), 1,
                    1'($urandom_range(0, 1)), 0, t);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        idle_cycles(3);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_stream_tx.md
Name: conv_stream_tx

Overview:
- Transmit side of the convolver's pixel/kernel streaming interface.
- Buffers one kernel (KERNEL_SIZE² coefficients) and one image run (up to 2^ADDR_W pixels), loaded through a simple word-write port driven from the Wishbone/LA control logic.
- On start, replays them cycle-by-cycle onto the kernel_write_en/kernel_in and img_write_en/img_input lines of the convolve block: kernel first, then pixels.
- Supports stalling, kernel-skip for re-runs, and a done pulse.

Parameters:
- BITS, 9, width of each pixel and kernel word.
- KERNEL_SIZE, 3, kernel edge length; kernel buffer holds KERNEL_SIZE*KERNEL_SIZE words.
- ADDR_W, 6, image buffer address width; image buffer depth IMG_DEPTH = 2^ADDR_W.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_sel  in  1  0 = image buffer, 1 = kernel buffer.
- wr_addr  in  ADDR_W  word address.
- wr_data  in  BITS  word to store.
- start  in  1  begin transmission (sampled in IDLE only).
- skip_kernel  in  1  sampled with start; 1 = omit kernel phase.
- img_len  in  ADDR_W+1  pixels to send; sampled with start.
- hold  in  1  stall; no word emitted while high.
- kernel_write_en  out  1  kernel word valid.
- kernel_out  out  BITS  kernel word.
- img_write_en  out  1  pixel valid.
- img_out  out  BITS  pixel.
- busy  out  1  high in KERNEL or IMAGE state.
- done  out  1  one-cycle pulse after last word.

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE; indices = 0.
  - kernel_write_en, kernel_out, img_write_en, img_out, busy, done all 0 immediately.
  - Buffer contents are not reset.
- All outputs are registered.
- Buffer writes:
  - Accepted only when state = IDLE; ignored while busy or done.
  - Kernel writes with wr_addr >= KERNEL_SIZE² are ignored.
  - A write in the same cycle as start is accepted, and the new value is transmitted.
- FSM states: IDLE, KERNEL, IMAGE, DONE.
  - IDLE: start=1 latches len = min(img_len, IMG_DEPTH) and clears indices. Next state is KERNEL if skip_kernel=0; otherwise IMAGE if len>0; otherwise DONE.
  - KERNEL: each cycle with hold=0 emits kernel_write_en=1 and kernel_out=kbuf[kidx], then kidx++. After word KERNEL_SIZE²-1, next state is IMAGE if len>0, else DONE.
  - IMAGE: each cycle with hold=0 emits img_write_en=1 and img_out=ibuf[iidx], then iidx++. After pixel len-1, next state is DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- hold=1:
  - Enables are 0 that cycle; data outputs keep their last value; indices and state are frozen.
  - Hold is ignored in IDLE and DONE.
- Enables drop to 0 in every non-emitting cycle; data outputs are don't-care when the enable is 0 and hold their last value.
- Latency with no hold, start sampled at edge t:
  - First kernel word is valid in cycle t+1.
  - First pixel is valid in cycle t+1+KERNEL_SIZE².
  - done is high in cycle t+1+KERNEL_SIZE²+len.
- Phase boundaries:
  - No bubble between the last kernel word and the first pixel.
  - No bubble between consecutive pixels.
- busy is high exactly while in KERNEL or IMAGE; it is low during the done cycle.
- start while busy or done is ignored (not queued).
- img_len > IMG_DEPTH is clamped to IMG_DEPTH.
- Reset mid-transmission aborts immediately: enables drop, and no done is produced.
- Downstream kernel memory accepts only one kernel per its reset. Re-runs without resetting the convolver must use skip_kernel=1; this block does not track downstream state.

Test Plan:
- Load kbuf = 1..9 and ibuf[0..3] = 10,11,12,13; start with img_len=4, skip_kernel=0 -> kernel_write_en high for cycles t+1..t+9 with kernel_out 1..9; img_write_en high for t+10..t+13 with img_out 10..13; done at t+14; busy high for t+1..t+13.
- Same load; start with skip_kernel=1, img_len=2 -> no kernel_write_en; pixels 10,11 at t+1 and t+2; done at t+3.
- Assert hold for 2 cycles after the 3rd kernel word -> kernel_write_en low for those 2 cycles; kernel_out stays 3; 4th word follows; done is delayed by exactly 2 cycles.
- img_len=0, skip_kernel=1 -> done at t+1 with no enables. img_len=100 with ADDR_W=6 -> exactly 64 pixels sent.
- Write ibuf[0]=0x1FF and assert start while busy -> ibuf[0] is unchanged on the next run, and the second start causes no restart.
- Pull reset_n low during the IMAGE phase -> all outputs are 0 asynchronously, no done pulse; after release, a new start transmits from index 0.
